fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
Instruction fetch stage that sits directly upstream of decode and the immediate extender. It owns the PC, issues word requests to instruction memory over a valid/ready request channel, and collects in-order responses into a small instruction queue. It presents {instr, instr_pc} to decode over a valid/ready handshake. Decode slices instr[31:7] for the extender. Branch/jump redirects flush the queue and discard in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
DEPTH, 2, queue entries; also the credit limit on outstanding+buffered fetches (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  synchronous reset, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  word-aligned fetch address (bits[1:0]=0)
imem_rsp_valid  in  1  response valid; in order, >=1 cycle after accept, no backpressure
imem_rdata  in  32  instruction word
redirect_valid  in  1  control-flow redirect from execute
redirect_pc  in  32  redirect target
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts head
instr  out  32  head instruction word
instr_pc  out  32  PC of head instruction

Behaviour:
- Reset (reset_n=0 at clk edge): pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, drop=0. During reset and the cycle after release, outputs are imem_req_valid=0, instr_valid=0, imem_addr=RESET_PC.
- Reset mid-operation: all state returns to reset values. Responses arriving after reset to pre-reset requests are the memory's responsibility; the bench resets memory together with this block.
- Credit: imem_req_valid = (outstanding + count < DEPTH) && !redirect_valid, combinational.
- imem_addr = pc. On imem_req_valid && imem_req_ready: pc <= pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), outstanding++.
- Response, with drop>0: word discarded, drop--, outstanding--.
- Response, with drop==0: push {imem_rdata, rsp_pc}, rsp_pc <= rsp_pc+4, outstanding--.
- Accept and response in the same cycle: outstanding unchanged.
- The credit rule guarantees a push never finds the queue full. Overflow is an assertion failure, not handled.
- instr_valid = (count!=0). instr and instr_pc come from the head entry, registered storage, no comb path from imem_rdata.
- Pop on instr_valid && instr_ready. Push and pop in the same cycle are allowed at any occupancy, and count stays the same.
- Latency: a request accepted in cycle N with response in cycle N+k gives instr_valid at N+k+1. Minimum request-to-decode latency is 2 cycles.
- Redirect (redirect_valid=1), highest priority:
  - queue flushed (count=0), including an entry pushed or popped this cycle; a pop handshake in that cycle still counts as consumed
  - no request issued this cycle
  - a response arriving this cycle is discarded
  - drop <= outstanding minus (1 if a response arrived this cycle), i.e. all still in-flight
  - pc <= {redirect_pc[31:2],2'b00}, rsp_pc <= same
  - fetch from the new pc may start the next cycle
- Back-to-back redirects: each one recomputes drop from the current outstanding. Drop never underflows.
- imem_req_ready low: the request is held with a stable imem_addr. pc does not advance.
- instr_ready low: the queue fills to DEPTH minus outstanding, then requests stall. No word is lost or duplicated.

Test Plan:
1. Reset release with memory fixed at 1-cycle latency and instr_ready=1 -> imem_addr sequence 0,4,8,…. instr_pc 0,4,8 appear in order with the matching instr, first instr_valid 2 cycles after the first accept. Sustained 1 instr/cycle throughput is not required; correct ordering is.
2. instr_ready=0 for 10 cycles -> at most DEPTH entries plus outstanding in flight. imem_req_valid drops. On release, instructions 0,4 come out with no gap or duplicate, then fetch resumes at 8.
3. Memory latency 3 with 2 outstanding, redirect_valid to 0x100 -> both stale responses dropped. The next instr_valid carries instr_pc=0x100 with its word. No stale instr_pc (8, C) ever appears.
4. Redirect in the same cycle as a response and an instr handshake -> response discarded, drop=outstanding-1, queue empty next cycle, fetch restarts at the target. redirect_pc=0x103 gives imem_addr 0x100.
5. imem_req_ready held low for 5 cycles -> imem_req_valid=1 with imem_addr stable throughout. Accept on the 6th cycle -> pc+4 follows.
6. Start at pc=0xFFFF_FFF8 via redirect -> fetches FFF8, FFFC, 0000_0000 in order. Then assert reset_n=0 mid-stream -> next cycle instr_valid=0, imem_req_valid=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect and decode handoff.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_buffer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and
// queues in-order responses for decode; redirects flush the queue and drop in-flight words.
module fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic            clk,
    input logic            reset_n,
    fetch_buffer_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t          q [DEPTH];
    logic [31:0]     pc;
    logic [31:0]     rsp_pc;
    logic [31:0]     target;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            run;
    logic            credit_ok;
    logic            req_valid_c;
    logic            accept;
    logic            rsp;
    logic            push;
    logic            pop;

    // Handshake decode; run keeps requests off for the first cycle after reset release
    always_comb begin
        credit_ok   = (SW'(outstanding) + SW'(count)) < SW'(DEPTH);
        req_valid_c = reset_n && run && credit_ok && !bus.redirect_valid;
        accept      = req_valid_c && bus.imem_req_ready;
        rsp         = bus.imem_rsp_valid;
        push        = rsp && (drop == '0) && !bus.redirect_valid;
        pop         = (count != '0) && bus.instr_ready;
        target      = bus.redirect_pc & 32'hFFFF_FFFC;
    end

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_addr      = pc;
    assign bus.instr_valid    = (count != '0);
    assign bus.instr          = q[rd_ptr].word;
    assign bus.instr_pc       = q[rd_ptr].pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            run         <= 1'b0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            if (bus.redirect_valid) begin
                // Everything still in flight after this cycle's response must be discarded
                pc     <= target;
                rsp_pc <= target;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                drop   <= (rsp && (outstanding != '0)) ? outstanding - CW'(1) : outstanding;
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (rsp && (drop != '0)) drop <= drop - CW'(1);
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= '{word: bus.imem_rdata, pc: rsp_pc};
    end

    // Credit accounting must make a push into a full queue impossible
    always_ff @(posedge clk) begin
        if (reset_n && push && !pop) assert (count < CW'(DEPTH));
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: in-order fetch, backpressure, redirects, PC wrap and reset.
// Memory model returns ~addr as the instruction word with a programmable in-order latency.
module tb_fetch_buffer;
    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    int   lat;
    int   cyc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    fetch_buffer_if b();

    fetch_buffer #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-order instruction memory, reset together with the DUT
    always @(posedge clk) begin
        int now;
        mreq_t e;
        now = cyc;
        cyc = cyc + 1;
        if (!reset_n) begin
            mq.delete();
            b.imem_rsp_valid <= 1'b0;
            b.imem_rdata     <= 32'h0;
        end else begin
            if (b.imem_req_valid && b.imem_req_ready) begin
                e.addr = b.imem_addr;
                e.due  = now + lat;
                mq.push_back(e);
            end
            if (mq.size() != 0 && mq[0].due == now + 1) begin
                b.imem_rsp_valid <= 1'b1;
                b.imem_rdata     <= ~mq[0].addr;
                void'(mq.pop_front());
            end else begin
                b.imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        lat     = 1;
        reset_n          = 1'b0;
        b.imem_req_ready = 1'b1;
        b.redirect_valid = 1'b0;
        b.redirect_pc    = 32'h0;
        b.instr_ready    = 1'b0;

        // Reset state
        step(); step(); step(); #1;
        chk("rst_req_valid", 32'(b.imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(b.instr_valid), 32'd0);
        chk("rst_addr", b.imem_addr, 32'h0);
        reset_n = 1'b1;
        b.instr_ready = 1'b1;
        #1;
        chk("rel_req_valid", 32'(b.imem_req_valid), 32'd0);

        // Sequential fetch, 1-cycle memory
        step(); #1;
        chk("t1_a0_req_valid", 32'(b.imem_req_valid), 32'd1);
        chk("t1_a0_addr", b.imem_addr, 32'h0);
        step(); #1;
        chk("t1_a1_instr_valid", 32'(b.instr_valid), 32'd0);
        chk("t1_a1_addr", b.imem_addr, 32'h4);
        step(); #1;
        chk("t1_a2_instr_valid", 32'(b.instr_valid), 32'd1);
        chk("t1_a2_instr", b.instr, 32'hFFFF_FFFF);
        chk("t1_a2_pc", b.instr_pc, 32'h0);
        chk("t1_a2_req_valid", 32'(b.imem_req_valid), 32'd0);
        step(); #1;
        chk("t1_a3_pc", b.instr_pc, 32'h4);
        chk("t1_a3_instr", b.instr, 32'hFFFF_FFFB);
        chk("t1_a3_addr", b.imem_addr, 32'h8);
        step(); #1;
        chk("t1_a4_instr_valid", 32'(b.instr_valid), 32'd0);
        chk("t1_a4_addr", b.imem_addr, 32'hC);

        // Decode stalls for 10 cycles
        step();
        b.instr_ready = 1'b0;
        #1;
        chk("t2_a5_pc", b.instr_pc, 32'h8);
        chk("t2_a5_req_valid", 32'(b.imem_req_valid), 32'd0);
        for (int i = 0; i < 9; i++) begin
            step(); #1;
            chk("t2_stall_req_valid", 32'(b.imem_req_valid), 32'd0);
            chk("t2_stall_pc", b.instr_pc, 32'h8);
        end
        step();
        b.instr_ready = 1'b1;
        #1;
        chk("t2_rel_pc0", b.instr_pc, 32'h8);
        chk("t2_rel_valid0", 32'(b.instr_valid), 32'd1);
        step(); #1;
        chk("t2_rel_pc1", b.instr_pc, 32'hC);
        chk("t2_rel_instr1", b.instr, 32'hFFFF_FFF3);
        chk("t2_resume_addr", b.imem_addr, 32'h10);
        step(); #1;
        chk("t2_gap_valid", 32'(b.instr_valid), 32'd0);
        step(); #1;
        chk("t2_next_pc", b.instr_pc, 32'h10);
        chk("t2_next_instr", b.instr, 32'hFFFF_FFEF);

        // Redirect with two 3-cycle fetches in flight
        lat = 3;
        do_reset();
        step();
        step(); #1;
        chk("t3_a1_addr", b.imem_addr, 32'h4);
        step();
        b.redirect_valid = 1'b1;
        b.redirect_pc    = 32'h100;
        #1;
        chk("t3_redir_req_valid", 32'(b.imem_req_valid), 32'd0);
        step();
        b.redirect_valid = 1'b0;
        #1;
        chk("t3_a3_instr_valid", 32'(b.instr_valid), 32'd0);
        chk("t3_a3_req_valid", 32'(b.imem_req_valid), 32'd0);
        step(); #1;
        chk("t3_a4_instr_valid", 32'(b.instr_valid), 32'd0);
        chk("t3_a4_addr", b.imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("t3_no_stale", 32'(b.instr_valid), 32'd0);
        end
        step(); #1;
        chk("t3_target_pc", b.instr_pc, 32'h100);
        chk("t3_target_instr", b.instr, 32'hFFFF_FEFF);
        step(); #1;
        chk("t3_next_pc", b.instr_pc, 32'h104);

        // Redirect coinciding with a response and a decode handshake
        lat = 1;
        do_reset();
        step();
        step();
        step();
        b.redirect_valid = 1'b1;
        b.redirect_pc    = 32'h103;
        #1;
        chk("t4_handshake_valid", 32'(b.instr_valid), 32'd1);
        chk("t4_handshake_pc", b.instr_pc, 32'h0);
        chk("t4_redir_req_valid", 32'(b.imem_req_valid), 32'd0);
        step();
        b.redirect_valid = 1'b0;
        #1;
        chk("t4_flush_valid", 32'(b.instr_valid), 32'd0);
        chk("t4_restart_valid", 32'(b.imem_req_valid), 32'd1);
        chk("t4_restart_addr", b.imem_addr, 32'h100);
        step();
        step(); #1;
        chk("t4_target_pc", b.instr_pc, 32'h100);
        chk("t4_target_instr", b.instr, 32'hFFFF_FEFF);

        // Memory holds off the request for 5 cycles
        do_reset();
        b.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk("t5_hold_valid", 32'(b.imem_req_valid), 32'd1);
            chk("t5_hold_addr", b.imem_addr, 32'h0);
        end
        step();
        b.imem_req_ready = 1'b1;
        #1;
        chk("t5_accept_addr", b.imem_addr, 32'h0);
        step(); #1;
        chk("t5_next_addr", b.imem_addr, 32'h4);
        step(); #1;
        chk("t5_first_pc", b.instr_pc, 32'h0);

        // PC wrap from the top of the address space, then reset mid-stream
        do_reset();
        step();
        b.redirect_valid = 1'b1;
        b.redirect_pc    = 32'hFFFF_FFF8;
        #1;
        chk("t6_redir_req_valid", 32'(b.imem_req_valid), 32'd0);
        step();
        b.redirect_valid = 1'b0;
        #1;
        chk("t6_addr_fff8", b.imem_addr, 32'hFFFF_FFF8);
        step(); #1;
        chk("t6_addr_fffc", b.imem_addr, 32'hFFFF_FFFC);
        step(); #1;
        chk("t6_pc_fff8", b.instr_pc, 32'hFFFF_FFF8);
        chk("t6_instr_fff8", b.instr, 32'h0000_0007);
        step(); #1;
        chk("t6_pc_fffc", b.instr_pc, 32'hFFFF_FFFC);
        chk("t6_addr_wrap", b.imem_addr, 32'h0);
        step(); #1;
        chk("t6_addr_4", b.imem_addr, 32'h4);
        step(); #1;
        chk("t6_pc_wrap", b.instr_pc, 32'h0);
        chk("t6_instr_wrap", b.instr, 32'hFFFF_FFFF);
        reset_n = 1'b0;
        #1;
        chk("t6_in_rst_req_valid", 32'(b.imem_req_valid), 32'd0);
        step(); #1;
        chk("t6_rst_instr_valid", 32'(b.instr_valid), 32'd0);
        chk("t6_rst_req_valid", 32'(b.imem_req_valid), 32'd0);
        chk("t6_rst_addr", b.imem_addr, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("t6_rel_req_valid", 32'(b.imem_req_valid), 32'd0);
        step(); #1;
        chk("t6_restart_valid", 32'(b.imem_req_valid), 32'd1);
        chk("t6_restart_addr", b.imem_addr, 32'h0);
        step(); #1;
        chk("t6_restart_next", b.imem_addr, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
